// File: rtl/ram_bank.sv
// ram_bank: single-port synchronous RAM bank with byte enables,
// registered reads of latency 1 or 2, and a zero-fill sequencer after reset.
module ram_bank #(
  parameter int ADR_W     = 16,
  parameter int DATA_W    = 64,
  parameter int READ_LAT  = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              writeEn,
  input  logic [ADR_W-1:0]  adr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [DATA_W/8-1:0] byteEn,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] readData,
  output logic              readValid
);

  localparam int DEPTH = 2 ** ADR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {INIT, RUN} state_t;

  state_t state, stateNext;
  logic [ADR_W-1:0] fillCnt, fillCntNext;

  logic [DATA_W-1:0] mem [DEPTH];

  logic wrAcc, rdAcc;
  logic [DATA_W-1:0] d1;
  logic v1;

  assign ready = (state == RUN);
  assign busy  = (state == INIT);
  assign wrAcc = req & ready & writeEn;
  assign rdAcc = req & ready & ~writeEn;

  // state and fill counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (INIT_ZERO != 0) ? INIT : RUN;
      fillCnt <= '0;
    end else begin
      state   <= stateNext;
      fillCnt <= fillCntNext;
    end
  end

  // fill sequencing: leave INIT once the last word is written
  always_comb begin
    stateNext   = state;
    fillCntNext = fillCnt;
    if (state == INIT) begin
      fillCntNext = fillCnt + {{(ADR_W-1){1'b0}}, 1'b1};
      if (fillCnt == {ADR_W{1'b1}}) stateNext = RUN;
    end
  end

  // array writes: zero-fill during INIT, byte-masked writes in RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[fillCnt] <= '0;
      end else if (wrAcc) begin
        for (int i = 0; i < NB; i++) begin
          if (byteEn[i]) mem[adr][8*i +: 8] <= writeData[8*i +: 8];
        end
      end
    end
  end

  // first read stage: sample the array at the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rdAcc;
      if (rdAcc) d1 <= mem[adr];
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] d2;
    logic v2;

    // second read stage; data only moves with a valid beat
    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end

    assign readData  = d2;
    assign readValid = v2;
  end else begin : g_lat1
    assign readData  = d1;
    assign readValid = v1;
  end

endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: three ram_bank instances (lat1/fill, lat2/fill, lat1/no-fill)
// driven alike; a queue scoreboard checks each against a word-level model.
module tb_ram_bank;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int N  = 16;
  localparam int LATS [3] = '{1, 2, 1};
  localparam int IZS  [3] = '{1, 1, 0};

  typedef struct {
    logic [63:0] d;
    logic [7:0]  m;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic writeEn = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [DW-1:0] writeData = '0;
  logic [7:0] byteEn = '0;

  logic rdy [3];
  logic bsy [3];
  logic [DW-1:0] rd [3];
  logic rv [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 0;

  logic [63:0] mm [3][N];
  logic [7:0]  mk [3][N];
  int fillLeft [3];
  logic [63:0] lastD [3];
  logic [7:0]  lastM [3];
  exp_t q [3][$];

  always #5 clk = ~clk;

  ram_bank #(.ADR_W(AW), .DATA_W(DW), .READ_LAT(1), .INIT_ZERO(1)) u0 (
    .clk(clk), .rst(rst), .req(req), .writeEn(writeEn), .adr(adr),
    .writeData(writeData), .byteEn(byteEn), .ready(rdy[0]), .busy(bsy[0]),
    .readData(rd[0]), .readValid(rv[0]));

  ram_bank #(.ADR_W(AW), .DATA_W(DW), .READ_LAT(2), .INIT_ZERO(1)) u1 (
    .clk(clk), .rst(rst), .req(req), .writeEn(writeEn), .adr(adr),
    .writeData(writeData), .byteEn(byteEn), .ready(rdy[1]), .busy(bsy[1]),
    .readData(rd[1]), .readValid(rv[1]));

  ram_bank #(.ADR_W(AW), .DATA_W(DW), .READ_LAT(1), .INIT_ZERO(0)) u2 (
    .clk(clk), .rst(rst), .req(req), .writeEn(writeEn), .adr(adr),
    .writeData(writeData), .byteEn(byteEn), .ready(rdy[2]), .busy(bsy[2]),
    .readData(rd[2]), .readValid(rv[2]));

  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      fillLeft[k] = 0;
      lastD[k] = '0;
      lastM[k] = '0;
      for (int a = 0; a < N; a++) begin
        mm[k][a] = '0;
        mk[k][a] = '0;
      end
    end
  end

  // reference model: word array, fill countdown, expected-read queue
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        started = 1;
        fillLeft[k] = (IZS[k] != 0) ? N : 0;
        q[k].delete();
        lastD[k] = '0;
        lastM[k] = 8'hFF;
      end else if (fillLeft[k] > 0) begin
        mm[k][N - fillLeft[k]] = '0;
        mk[k][N - fillLeft[k]] = 8'hFF;
        fillLeft[k]--;
      end else if (req) begin
        if (writeEn) begin
          for (int b = 0; b < 8; b++) begin
            if (byteEn[b]) begin
              mm[k][adr][8*b +: 8] = writeData[8*b +: 8];
              mk[k][adr][b] = 1'b1;
            end
          end
        end else begin
          q[k].push_back('{d: mm[k][adr], m: mk[k][adr],
                           due: cyc + LATS[k] - 1});
        end
      end
    end
  end

  // monitor: compare DUT outputs with the scoreboard away from the edge
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        logic [63:0] em;
        checks++;
        if (rdy[k] !== (fillLeft[k] == 0)) begin
          failures++;
          $display("FAIL ready u%0d cyc=%0d got=%b exp=%b",
                   k, cyc, rdy[k], (fillLeft[k] == 0));
        end
        checks++;
        if (bsy[k] !== (fillLeft[k] != 0)) begin
          failures++;
          $display("FAIL busy u%0d cyc=%0d got=%b exp=%b",
                   k, cyc, bsy[k], (fillLeft[k] != 0));
        end
        if (q[k].size() > 0 && q[k][0].due == cyc) begin
          exp_t e;
          e = q[k].pop_front();
          em = expand(e.m);
          checks++;
          if (rv[k] !== 1'b1) begin
            failures++;
            $display("FAIL readValid u%0d cyc=%0d got=%b exp=1",
                     k, cyc, rv[k]);
          end
          checks++;
          if ((rd[k] & em) !== (e.d & em)) begin
            failures++;
            $display("FAIL readData u%0d cyc=%0d got=%h exp=%h",
                     k, cyc, rd[k] & em, e.d & em);
          end
          lastD[k] = e.d;
          lastM[k] = e.m;
        end else begin
          em = expand(lastM[k]);
          checks++;
          if (rv[k] !== 1'b0) begin
            failures++;
            $display("FAIL idleValid u%0d cyc=%0d got=%b exp=0",
                     k, cyc, rv[k]);
          end
          checks++;
          if ((rd[k] & em) !== (lastD[k] & em)) begin
            failures++;
            $display("FAIL holdData u%0d cyc=%0d got=%h exp=%h",
                     k, cyc, rd[k] & em, lastD[k] & em);
          end
        end
      end
    end
  end

  task automatic op(input logic r, input logic we, input logic [AW-1:0] a,
                    input logic [63:0] d, input logic [7:0] be);
    @(negedge clk);
    req = r;
    writeEn = we;
    adr = a;
    writeData = d;
    byteEn = be;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic pulseRst();
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) op(1'b1, 1'b1, 4'd5, 64'd99, 8'hFF);
    pulseRst();
    for (int i = 0; i < 4; i++) op(1'b1, 1'b1, 4'd5, 64'd99, 8'hFF);
    idle(16);
    for (int a = 0; a < N; a++) op(1'b1, 1'b0, a[AW-1:0], '0, '0);
    idle(3);
    op(1'b1, 1'b1, 4'd3, 64'h1122334455667788, 8'hFF);
    op(1'b1, 1'b1, 4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    op(1'b1, 1'b0, 4'd3, '0, '0);
    idle(3);
    op(1'b1, 1'b1, 4'd1, 64'd10, 8'hFF);
    op(1'b1, 1'b1, 4'd2, 64'd20, 8'hFF);
    op(1'b1, 1'b1, 4'd3, 64'd30, 8'hFF);
    for (int a = 1; a <= 3; a++) op(1'b1, 1'b0, a[AW-1:0], '0, '0);
    idle(3);
    op(1'b1, 1'b1, 4'd9, 64'd77, 8'hFF);
    op(1'b1, 1'b0, 4'd9, '0, '0);
    op(1'b1, 1'b1, 4'd10, 64'd5, 8'h00);
    idle(5);
    op(1'b1, 1'b1, 4'd7, 64'd42, 8'hFF);
    op(1'b1, 1'b0, 4'd7, '0, '0);
    pulseRst();
    idle(20);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        pulseRst();
      end else begin
        op(1'($urandom_range(3) != 0), 1'($urandom_range(1)),
           AW'($urandom_range(N - 1)),
           {$urandom, $urandom}, 8'($urandom));
      end
    end
    idle(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
